data_array_arbiter: RTL and testbench

//  Single-port sequencer in front of data_array. Shares one port between three requesters:
//   - CPU word read/write
//   - refill engine (line write)
//   - writeback engine (line read)

---
 rtl/cache_pkg.sv | 35 +++
 rtl/data_arb_priority.sv | 27 ++
 rtl/data_array_arbiter.sv | 176 +++++++++++++++++
 tb/tb_data_array_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the data_array port arbiter.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_WORD,
    WAIT_LINE
  } arb_state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_CPU,
    SEL_FILL,
    SEL_WB
  } req_sel_t;

  // A single set/way/byte still needs a one-bit field, so never return zero.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int idx_w(input int num_sets);
    return clog2_min1(num_sets);
  endfunction

  function automatic int way_w(input int associativity);
    return clog2_min1(associativity);
  endfunction

  function automatic int off_w(input int line_size);
    return clog2_min1(line_size);
  endfunction

endpackage

// File: rtl/data_arb_priority.sv
// Winner select for the shared data_array port: wb > fill > cpu, unless the
// CPU has been starved long enough to jump the queue.
module data_arb_priority
  import cache_pkg::*;
(
  input  logic     cpu_valid,
  input  logic     fill_valid,
  input  logic     wb_valid,
  input  logic     cpu_starved,
  output req_sel_t sel
);

  // Fixed priority with a starvation override for the CPU.
  always_comb begin
    sel = SEL_NONE;
    if (cpu_valid && cpu_starved) begin
      sel = SEL_CPU;
    end else if (wb_valid) begin
      sel = SEL_WB;
    end else if (fill_valid) begin
      sel = SEL_FILL;
    end else if (cpu_valid) begin
      sel = SEL_CPU;
    end
  end

endmodule

// File: rtl/data_array_arbiter.sv
// Single-port sequencer in front of data_array: grants one of CPU / refill /
// writeback, issues a one-cycle array command and routes read data back.
module data_array_arbiter
  import cache_pkg::*;
#(
  parameter int  LINE_SIZE     = 64,
  parameter int  NUM_SETS      = 64,
  parameter int  ASSOCIATIVITY = 4,
  parameter int  DATA_WIDTH    = 32,
  parameter int  STARVE_LIMIT  = 8,
  localparam int IDX_W         = idx_w(NUM_SETS),
  localparam int WAY_W         = way_w(ASSOCIATIVITY),
  localparam int OFF_W         = off_w(LINE_SIZE),
  localparam int LINE_W        = LINE_SIZE * 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_valid,
  output logic                  cpu_ready,
  input  logic                  cpu_we,
  input  logic [IDX_W-1:0]      cpu_index,
  input  logic [WAY_W-1:0]      cpu_way,
  input  logic [OFF_W-1:0]      cpu_offset,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_rsp_valid,
  output logic [DATA_WIDTH-1:0] cpu_rsp_data,
  input  logic                  fill_valid,
  output logic                  fill_ready,
  input  logic [IDX_W-1:0]      fill_index,
  input  logic [WAY_W-1:0]      fill_way,
  input  logic [LINE_W-1:0]     fill_data,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [IDX_W-1:0]      wb_index,
  input  logic [WAY_W-1:0]      wb_way,
  output logic                  wb_rsp_valid,
  output logic [LINE_W-1:0]     wb_rsp_data,
  output logic                  arr_read_en,
  output logic                  arr_write_en,
  output logic                  arr_line_write_en,
  output logic                  arr_line_read_en,
  output logic [IDX_W-1:0]      arr_index,
  output logic [WAY_W-1:0]      arr_way,
  output logic [OFF_W-1:0]      arr_offset,
  output logic [DATA_WIDTH-1:0] arr_write_data,
  output logic [LINE_W-1:0]     arr_line_write_data,
  input  logic [DATA_WIDTH-1:0] arr_read_data,
  input  logic [LINE_W-1:0]     arr_line_read_data
);

  localparam int               WORD_LSB   = $clog2(DATA_WIDTH / 8);
  localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [OFF_W-1:0] WORD_MASK  = ~OFF_W'((1 << WORD_LSB) - 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_reg, state_next;
  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
  req_sel_t         sel;
  logic             cpu_accept, fill_accept, wb_accept;
  logic             cpu_rsp_valid_reg, wb_rsp_valid_reg;

  data_arb_priority u_priority (
    .cpu_valid   (cpu_valid),
    .fill_valid  (fill_valid),
    .wb_valid    (wb_valid),
    .cpu_starved (starve_cnt_reg == STARVE_MAX),
    .sel         (sel)
  );

  // Only the winner sees ready, only in IDLE; reset forces every ready low
  // even though the state register already reads IDLE.
  always_comb begin
    cpu_ready  = 1'b0;
    fill_ready = 1'b0;
    wb_ready   = 1'b0;
    if (rst_n && (state_reg == IDLE)) begin
      cpu_ready  = (sel == SEL_CPU);
      fill_ready = (sel == SEL_FILL);
      wb_ready   = (sel == SEL_WB);
    end
  end

  assign cpu_accept  = cpu_valid  && cpu_ready;
  assign fill_accept = fill_valid && fill_ready;
  assign wb_accept   = wb_valid   && wb_ready;

  // Next state and starvation count; reads wait one extra cycle for the array.
  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    case (state_reg)
      IDLE:      if (sel != SEL_NONE) state_next = ISSUE;
      ISSUE: begin
        if (arr_read_en)           state_next = WAIT_WORD;
        else if (arr_line_read_en) state_next = WAIT_LINE;
        else                       state_next = IDLE;
      end
      WAIT_WORD: state_next = IDLE;
      WAIT_LINE: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (!cpu_valid || cpu_accept) begin
      starve_cnt_next = '0;
    end else if ((state_reg == IDLE) && (starve_cnt_reg != STARVE_MAX)) begin
      starve_cnt_next = starve_cnt_reg + CNT_W'(1);
    end
  end

  // State and starvation counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // Array command register: enables live for exactly the ISSUE cycle, the
  // address/data fields hold their last value until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr_read_en         <= 1'b0;
      arr_write_en        <= 1'b0;
      arr_line_write_en   <= 1'b0;
      arr_line_read_en    <= 1'b0;
      arr_index           <= '0;
      arr_way             <= '0;
      arr_offset          <= '0;
      arr_write_data      <= '0;
      arr_line_write_data <= '0;
    end else begin
      arr_read_en       <= 1'b0;
      arr_write_en      <= 1'b0;
      arr_line_write_en <= 1'b0;
      arr_line_read_en  <= 1'b0;
      if (cpu_accept) begin
        arr_read_en    <= !cpu_we;
        arr_write_en   <= cpu_we;
        arr_index      <= cpu_index;
        arr_way        <= cpu_way;
        arr_offset     <= cpu_offset & WORD_MASK;
        arr_write_data <= cpu_wdata;
      end else if (fill_accept) begin
        arr_line_write_en   <= 1'b1;
        arr_index           <= fill_index;
        arr_way             <= fill_way;
        arr_offset          <= '0;
        arr_line_write_data <= fill_data;
      end else if (wb_accept) begin
        arr_line_read_en <= 1'b1;
        arr_index        <= wb_index;
        arr_way          <= wb_way;
        arr_offset       <= '0;
      end
    end
  end

  // Response strobes fire in the cycle the array presents its read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rsp_valid_reg <= 1'b0;
      wb_rsp_valid_reg  <= 1'b0;
    end else begin
      cpu_rsp_valid_reg <= (state_reg == ISSUE) && arr_read_en;
      wb_rsp_valid_reg  <= (state_reg == ISSUE) && arr_line_read_en;
    end
  end

  assign cpu_rsp_valid = cpu_rsp_valid_reg;
  assign wb_rsp_valid  = wb_rsp_valid_reg;
  assign cpu_rsp_data  = cpu_rsp_valid_reg ? arr_read_data : '0;
  assign wb_rsp_data   = wb_rsp_valid_reg ? arr_line_read_data : '0;

endmodule

// File: tb/tb_data_array_arbiter.sv
// Scoreboard bench for data_array_arbiter with a behavioural data_array model.
module tb_data_array_arbiter;

  localparam int IDX_W = 6;
  localparam int WAY_W = 2;
  localparam int OFF_W = 6;
  localparam int DW    = 32;
  localparam int LW    = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             cpu_valid, cpu_ready, cpu_we, cpu_rsp_valid;
  logic [IDX_W-1:0] cpu_index;
  logic [WAY_W-1:0] cpu_way;
  logic [OFF_W-1:0] cpu_offset;
  logic [DW-1:0]    cpu_wdata, cpu_rsp_data;
  logic             fill_valid, fill_ready;
  logic [IDX_W-1:0] fill_index;
  logic [WAY_W-1:0] fill_way;
  logic [LW-1:0]    fill_data;
  logic             wb_valid, wb_ready, wb_rsp_valid;
  logic [IDX_W-1:0] wb_index;
  logic [WAY_W-1:0] wb_way;
  logic [LW-1:0]    wb_rsp_data;
  logic             arr_read_en, arr_write_en, arr_line_write_en, arr_line_read_en;
  logic [IDX_W-1:0] arr_index;
  logic [WAY_W-1:0] arr_way;
  logic [OFF_W-1:0] arr_offset;
  logic [DW-1:0]    arr_write_data, arr_read_data;
  logic [LW-1:0]    arr_line_write_data, arr_line_read_data;

  data_array_arbiter #(
    .LINE_SIZE(64), .NUM_SETS(64), .ASSOCIATIVITY(4), .DATA_WIDTH(32), .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we),
    .cpu_index(cpu_index), .cpu_way(cpu_way), .cpu_offset(cpu_offset), .cpu_wdata(cpu_wdata),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_index(fill_index),
    .fill_way(fill_way), .fill_data(fill_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_index(wb_index), .wb_way(wb_way),
    .wb_rsp_valid(wb_rsp_valid), .wb_rsp_data(wb_rsp_data),
    .arr_read_en(arr_read_en), .arr_write_en(arr_write_en),
    .arr_line_write_en(arr_line_write_en), .arr_line_read_en(arr_line_read_en),
    .arr_index(arr_index), .arr_way(arr_way), .arr_offset(arr_offset),
    .arr_write_data(arr_write_data), .arr_line_write_data(arr_line_write_data),
    .arr_read_data(arr_read_data), .arr_line_read_data(arr_line_read_data)
  );

  // Behavioural data_array: one-cycle registered read.
  logic [DW-1:0] word_mem [0:16383];
  logic [LW-1:0] line_mem [0:255];
  always @(posedge clk) begin
    if (arr_write_en)      word_mem[{arr_index, arr_way, arr_offset}] <= arr_write_data;
    if (arr_line_write_en) line_mem[{arr_index, arr_way}] <= arr_line_write_data;
    if (arr_read_en)       arr_read_data <= word_mem[{arr_index, arr_way, arr_offset}];
    if (arr_line_read_en)  arr_line_read_data <= line_mem[{arr_index, arr_way}];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]       en;   // {read, write, line_write, line_read}
    logic [IDX_W-1:0] idx;
    logic [WAY_W-1:0] way;
    logic [OFF_W-1:0] off;
    logic [DW-1:0]    wdata;
    logic [LW-1:0]    ldata;
    int               cyc;
  } cmd_t;
  typedef struct {
    logic [LW-1:0] data;
    int            cyc;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t cpu_q[$];
  rsp_t wb_q[$];

  int checks = 0;
  int errors = 0;
  int cpu_acc_cyc, fill_acc_cyc, wb_acc_cyc, wb_acc_cnt, wb_cnt_at_cpu;
  bit cpu_done;

  function automatic void chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endfunction

  // Monitor: pops expected commands/responses whenever the DUT presents one.
  always @(negedge clk) begin : monitor
    cmd_t       c;
    rsp_t       r;
    logic [3:0] en;
    en = {arr_read_en, arr_write_en, arr_line_write_en, arr_line_read_en};
    if (rst_n) begin
      if (en != 4'b0) begin
        chk("ready_during_issue", LW'({cpu_ready, fill_ready, wb_ready}), LW'(0));
        chk("cmd_expected", LW'(cmd_q.size() > 0), LW'(1));
        if (cmd_q.size() > 0) begin
          c = cmd_q.pop_front();
          $display("txn cyc=%0d en=%b idx=%0d way=%0d off=%0d wdata=%h", cyc, en, arr_index, arr_way, arr_offset, arr_write_data);
          chk("cmd_en", LW'(en), LW'(c.en));
          chk("cmd_cycle", LW'(cyc), LW'(c.cyc));
          chk("arr_index", LW'(arr_index), LW'(c.idx));
          chk("arr_way", LW'(arr_way), LW'(c.way));
          chk("arr_offset", LW'(arr_offset), LW'(c.off));
          if (c.en == 4'b0100) chk("arr_write_data", LW'(arr_write_data), LW'(c.wdata));
          if (c.en == 4'b0010) chk("arr_line_write_data", arr_line_write_data, c.ldata);
        end
      end
      if (cpu_rsp_valid) begin
        chk("ready_during_cpu_rsp", LW'({cpu_ready, fill_ready, wb_ready}), LW'(0));
        chk("cpu_rsp_expected", LW'(cpu_q.size() > 0), LW'(1));
        if (cpu_q.size() > 0) begin
          r = cpu_q.pop_front();
          $display("txn cyc=%0d cpu_rsp data=%h", cyc, cpu_rsp_data);
          chk("cpu_rsp_data", LW'(cpu_rsp_data), r.data);
          chk("cpu_rsp_cycle", LW'(cyc), LW'(r.cyc));
        end
      end
      if (wb_rsp_valid) begin
        chk("ready_during_wb_rsp", LW'({cpu_ready, fill_ready, wb_ready}), LW'(0));
        chk("wb_rsp_expected", LW'(wb_q.size() > 0), LW'(1));
        if (wb_q.size() > 0) begin
          r = wb_q.pop_front();
          $display("txn cyc=%0d wb_rsp data[31:0]=%h", cyc, wb_rsp_data[31:0]);
          chk("wb_rsp_data", wb_rsp_data, r.data);
          chk("wb_rsp_cycle", LW'(cyc), LW'(r.cyc));
        end
      end
      if ((int'(cpu_valid) + int'(fill_valid) + int'(wb_valid)) > 1)
        chk("single_ready", LW'((int'(cpu_ready) + int'(fill_ready) + int'(wb_ready)) <= 1), LW'(1));
    end
  end

  // For reads, data is the expected read word.
  task automatic cpu_req(input logic we, input logic [IDX_W-1:0] idx, input logic [WAY_W-1:0] way,
                         input logic [OFF_W-1:0] off, input logic [DW-1:0] data,
                         input logic [OFF_W-1:0] exp_off);
    cmd_t c;
    rsp_t r;
    int   n;
    cpu_valid = 1'b1; cpu_we = we; cpu_index = idx; cpu_way = way; cpu_offset = off;
    cpu_wdata = we ? data : '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!cpu_ready && n < 200);
    chk("cpu_grant", LW'(cpu_ready), LW'(1));
    if (cpu_ready) begin
      cpu_acc_cyc = cyc;
      wb_cnt_at_cpu = wb_acc_cnt;
      c.en = we ? 4'b0100 : 4'b1000;
      c.idx = idx; c.way = way; c.off = exp_off; c.wdata = data; c.ldata = '0; c.cyc = cyc + 1;
      cmd_q.push_back(c);
      if (!we) begin
        r.data = LW'(data); r.cyc = cyc + 2;
        cpu_q.push_back(r);
      end
      @(posedge clk);
    end
    #1 cpu_valid = 1'b0;
  endtask

  task automatic fill_req(input logic [IDX_W-1:0] idx, input logic [WAY_W-1:0] way, input logic [LW-1:0] line);
    cmd_t c;
    int   n;
    fill_valid = 1'b1; fill_index = idx; fill_way = way; fill_data = line;
    n = 0;
    do begin @(negedge clk); n++; end while (!fill_ready && n < 200);
    chk("fill_grant", LW'(fill_ready), LW'(1));
    if (fill_ready) begin
      fill_acc_cyc = cyc;
      c.en = 4'b0010; c.idx = idx; c.way = way; c.off = '0; c.wdata = '0; c.ldata = line; c.cyc = cyc + 1;
      cmd_q.push_back(c);
      @(posedge clk);
    end
    #1 fill_valid = 1'b0;
  endtask

  task automatic wb_req(input logic [IDX_W-1:0] idx, input logic [WAY_W-1:0] way, input logic [LW-1:0] exp_line);
    cmd_t c;
    rsp_t r;
    int   n;
    wb_valid = 1'b1; wb_index = idx; wb_way = way;
    n = 0;
    do begin @(negedge clk); n++; end while (!wb_ready && n < 200);
    chk("wb_grant", LW'(wb_ready), LW'(1));
    if (wb_ready) begin
      wb_acc_cyc = cyc;
      wb_acc_cnt++;
      c.en = 4'b0001; c.idx = idx; c.way = way; c.off = '0; c.wdata = '0; c.ldata = '0; c.cyc = cyc + 1;
      cmd_q.push_back(c);
      r.data = exp_line; r.cyc = cyc + 2;
      wb_q.push_back(r);
      @(posedge clk);
    end
    #1 wb_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [LW-1:0] line_a, line_b;
    cmd_t          c;
    int            n, first_acc, rsp_cnt;
    for (int k = 0; k < 16; k++) begin
      line_a[k*32 +: 32] = 32'hA5A5_0000 + 32'(k);
      line_b[k*32 +: 32] = 32'h5A5A_1000 + 32'(k);
    end
    cpu_we = 1'b0; cpu_index = '0; cpu_way = '0; cpu_offset = '0; cpu_wdata = '0;
    fill_index = '0; fill_way = '0; fill_data = '0; wb_index = '0; wb_way = '0;
    wb_acc_cnt = 0; cpu_done = 1'b0;
    // Reset with every requester asserting: nothing may be granted.
    cpu_valid = 1'b1; fill_valid = 1'b1; wb_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", LW'({cpu_ready, fill_ready, wb_ready}), LW'(0));
    chk("reset_en", LW'({arr_read_en, arr_write_en, arr_line_write_en, arr_line_read_en}), LW'(0));
    chk("reset_rsp_valid", LW'({cpu_rsp_valid, wb_rsp_valid}), LW'(0));
    chk("reset_addr", LW'({arr_index, arr_way, arr_offset, arr_write_data}), LW'(0));
    cpu_valid = 1'b0; fill_valid = 1'b0; wb_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: word write then read back; write frees the port after two cycles.
    cpu_req(1'b1, 6'd5, 2'd2, 6'd8, 32'hDEAD_BEEF, 6'd8);
    first_acc = cpu_acc_cyc;
    cpu_req(1'b0, 6'd5, 2'd2, 6'd8, 32'hDEAD_BEEF, 6'd8);
    chk("write_turnaround", LW'(cpu_acc_cyc - first_acc), LW'(2));

    // 4: offsets are forced word-aligned.
    cpu_req(1'b1, 6'd1, 2'd0, 6'd4, 32'h1234_5678, 6'd4);
    cpu_req(1'b0, 6'd1, 2'd0, 6'd6, 32'h1234_5678, 6'd4);
    cpu_req(1'b1, 6'd1, 2'd1, 6'd63, 32'hCAFE_F00D, 6'd60);
    cpu_req(1'b0, 6'd1, 2'd1, 6'd63, 32'hCAFE_F00D, 6'd60);

    // Line used by later writebacks.
    fill_req(6'd63, 2'd3, line_a);

    // 2: simultaneous requests resolve wb, fill, cpu.
    fork
      cpu_req(1'b0, 6'd1, 2'd0, 6'd4, 32'h1234_5678, 6'd4);
      fill_req(6'd7, 2'd1, line_b);
      wb_req(6'd63, 2'd3, line_a);
    join
    chk("order_fill_after_wb", LW'(fill_acc_cyc - wb_acc_cyc), LW'(3));
    chk("order_cpu_after_fill", LW'(cpu_acc_cyc - fill_acc_cyc), LW'(2));

    // 5: wb line read beside a waiting CPU read; no ready while busy.
    fork
      wb_req(6'd63, 2'd3, line_a);
      cpu_req(1'b0, 6'd5, 2'd2, 6'd8, 32'hDEAD_BEEF, 6'd8);
    join
    chk("cpu_after_wb_read", LW'(cpu_acc_cyc - wb_acc_cyc), LW'(3));
    wb_req(6'd7, 2'd1, line_b);

    // 3: continuous wb traffic; CPU must win after exactly 8 lost IDLE cycles.
    wb_acc_cnt = 0;
    cpu_done = 1'b0;
    fork
      begin
        cpu_req(1'b0, 6'd1, 2'd1, 6'd60, 32'hCAFE_F00D, 6'd60);
        cpu_done = 1'b1;
      end
      begin
        while (!cpu_done) wb_req(6'd63, 2'd3, line_a);
      end
    join
    chk("starve_losses", LW'(wb_cnt_at_cpu), LW'(8));

    // 6: reset while a line read is in WAIT_LINE.
    wb_valid = 1'b1; wb_index = 6'd10; wb_way = 2'd1;
    n = 0;
    do begin @(negedge clk); n++; end while (!wb_ready && n < 50);
    chk("wb_grant_reset_case", LW'(wb_ready), LW'(1));
    c.en = 4'b0001; c.idx = 6'd10; c.way = 2'd1; c.off = '0; c.wdata = '0; c.ldata = '0; c.cyc = cyc + 1;
    cmd_q.push_back(c);
    @(posedge clk);
    #1 wb_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("wb_rsp_before_reset", LW'(wb_rsp_valid), LW'(1));
    cpu_valid = 1'b1; fill_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", LW'({cpu_ready, fill_ready, wb_ready}), LW'(0));
    chk("async_rst_en", LW'({arr_read_en, arr_write_en, arr_line_write_en, arr_line_read_en}), LW'(0));
    chk("async_rst_rsp_valid", LW'({cpu_rsp_valid, wb_rsp_valid}), LW'(0));
    chk("async_rst_addr", LW'({arr_index, arr_way, arr_offset, arr_write_data}), LW'(0));
    chk("async_rst_line_data", arr_line_write_data, LW'(0));
    chk("async_rst_cpu_rsp_data", LW'(cpu_rsp_data), LW'(0));
    chk("async_rst_wb_rsp_data", wb_rsp_data, LW'(0));
    repeat (2) @(negedge clk);
    cpu_valid = 1'b0; fill_valid = 1'b0;
    rst_n = 1'b1;
    rsp_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (wb_rsp_valid) rsp_cnt++;
    end
    chk("no_wb_rsp_after_reset", LW'(rsp_cnt), LW'(0));
    @(posedge clk);
    #1;
    cpu_req(1'b0, 6'd5, 2'd2, 6'd8, 32'hDEAD_BEEF, 6'd8);

    repeat (5) @(posedge clk);
    #1;
    chk("cmd_q_drained", LW'(cmd_q.size()), LW'(0));
    chk("cpu_q_drained", LW'(cpu_q.size()), LW'(0));
    chk("wb_q_drained", LW'(wb_q.size()), LW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
